// File: rtl/a26_input_mux.sv
// a26_input_mux: controller front end between the hps_io joystick words and the
// Atari 2600 core. It maps sticks onto the two DB9 ports, emulates four analog
// paddles against the TIA pot ramp, stretches the console switches and toggles B/W.
// Optional macro A26_KEY_INPUT_EN adds a ps2_key input (F1 start, F2 select, F3 B/W).
module a26_input_mux #(
    parameter int NUM_JOY     = 2,
    parameter int PAD_BITS    = 8,
    parameter int PAD_STEP    = 4,
    parameter int RAMP_DIV    = 57,
    parameter int SWITCH_HOLD = 3
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [NUM_JOY*16-1:0]   joy_i,
    input  logic [1:0]              mode,
    input  logic                    vsync,
    input  logic                    pot_dump,
`ifdef A26_KEY_INPUT_EN
    input  logic [10:0]             ps2_key,
`endif
    output logic [3:0]              ctl_l,
    output logic [3:0]              ctl_r,
    output logic                    trig_l,
    output logic                    trig_r,
    output logic [4*PAD_BITS-1:0]   pad_pos,
    output logic [3:0]              pad_in,
    output logic                    game_reset,
    output logic                    game_select,
    output logic                    bw_col
);

    localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int HOLD_W = (SWITCH_HOLD > 0) ? $clog2(SWITCH_HOLD + 1) : 1;
    localparam logic [PAD_BITS-1:0] PAD_MAX    = '1;
    localparam logic [PAD_BITS-1:0] PAD_CENTRE = PAD_BITS'(1) << (PAD_BITS - 1);
    localparam logic [PAD_BITS-1:0] PAD_INC    = PAD_BITS'(PAD_STEP);
    localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(RAMP_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LOAD  = HOLD_W'(SWITCH_HOLD);

    logic [NUM_JOY*16-1:0] joy_q, joy_d;
    logic                  vsync_q, vsync_d, vsync_prev_q, vsync_prev_d;
    logic                  pot_dump_q, pot_dump_d;
    logic                  start_prev_q, start_prev_d, select_prev_q, select_prev_d;
    logic [3:0]            bw_prev_q, bw_prev_d;
    logic [HOLD_W-1:0]     reset_hold_q, reset_hold_d, select_hold_q, select_hold_d;
    logic [PAD_BITS-1:0]   ramp_q, ramp_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [PAD_BITS-1:0]   pad_pos_q [4];
    logic [PAD_BITS-1:0]   pad_pos_d [4];
    logic [3:0]            ctl_l_q, ctl_l_d, ctl_r_q, ctl_r_d;
    logic                  trig_l_q, trig_l_d, trig_r_q, trig_r_d;
    logic [3:0]            pad_in_q, pad_in_d;
    logic                  game_reset_q, game_reset_d, game_select_q, game_select_d;
    logic                  bw_col_q, bw_col_d;

    logic [63:0]           joy_pad;
    logic [15:0]           joy_ext [4];
    logic [15:0]           mux_or, left_word, right_word;
    logic                  ftick, start_src, select_src, bw_rise, key_bw_toggle;
    logic                  unused_joy_bits;

`ifdef A26_KEY_INPUT_EN
    logic [10:0]           ps2_key_q, ps2_key_d;
    logic                  key_tgl_prev_q, key_tgl_prev_d;
    logic                  f1_down_q, f1_down_d, f2_down_q, f2_down_d;
    logic                  unused_key_bit;

    // Decode a PS/2 event (bit10 flip) into held F1/F2 state and an F3 press pulse.
    always_comb begin
        ps2_key_d      = ps2_key;
        key_tgl_prev_d = ps2_key_q[10];
        f1_down_d      = f1_down_q;
        f2_down_d      = f2_down_q;
        key_bw_toggle  = 1'b0;
        if (ps2_key_q[10] ^ key_tgl_prev_q) begin
            case (ps2_key_q[7:0])
                8'h05:   f1_down_d = ps2_key_q[9];
                8'h06:   f2_down_d = ps2_key_q[9];
                8'h04:   key_bw_toggle = ps2_key_q[9];
                default: key_bw_toggle = 1'b0;
            endcase
        end
    end

    assign unused_key_bit = ps2_key_q[8];
`else
    assign key_bw_toggle = 1'b0;
`endif

    // Spread the registered words into four slots; absent sticks read as all-zero.
    always_comb begin
        joy_pad = 64'(joy_q);
        for (int k = 0; k < 4; k++) begin
            joy_ext[k] = joy_pad[k*16 +: 16];
        end
    end

    // Spare button bits are carried in the word but have no function here.
    assign unused_joy_bits = ^joy_pad;

    // Combine all sticks into the merged word, switch sources and the B/W edge.
    always_comb begin
        mux_or     = '0;
        start_src  = 1'b0;
        select_src = 1'b0;
        bw_rise    = key_bw_toggle;
        for (int k = 0; k < 4; k++) begin
            mux_or     = mux_or | joy_ext[k];
            start_src  = start_src | joy_ext[k][7];
            select_src = select_src | joy_ext[k][8];
            bw_rise    = bw_rise | (joy_ext[k][11] & ~bw_prev_q[k]);
            bw_prev_d[k] = joy_ext[k][11];
        end
`ifdef A26_KEY_INPUT_EN
        start_src  = start_src | f1_down_q;
        select_src = select_src | f2_down_q;
`endif
    end

    // Input stage, port mapping, switch stretching and B/W toggle.
    always_comb begin
        joy_d        = joy_i;
        vsync_d      = vsync;
        pot_dump_d   = pot_dump;
        vsync_prev_d = vsync_q;
        ftick        = vsync_q & ~vsync_prev_q;

        left_word  = joy_ext[0];
        right_word = joy_ext[1];
        case (mode)
            2'd1: begin
                left_word  = mux_or;
                right_word = mux_or;
            end
            2'd2: begin
                left_word  = joy_ext[1];
                right_word = joy_ext[0];
            end
            default: begin
                left_word  = joy_ext[0];
                right_word = joy_ext[1];
            end
        endcase
        ctl_l_d  = left_word[3:0];
        ctl_r_d  = right_word[3:0];
        trig_l_d = left_word[4] | left_word[6];
        trig_r_d = right_word[4] | right_word[6];

        start_prev_d  = start_src;
        select_prev_d = select_src;
        reset_hold_d  = reset_hold_q;
        select_hold_d = select_hold_q;
        if (start_src && !start_prev_q)
            reset_hold_d = HOLD_LOAD;
        else if (ftick && !start_src && reset_hold_q != '0)
            reset_hold_d = reset_hold_q - 1'b1;
        if (select_src && !select_prev_q)
            select_hold_d = HOLD_LOAD;
        else if (ftick && !select_src && select_hold_q != '0)
            select_hold_d = select_hold_q - 1'b1;
        game_reset_d  = start_src | (reset_hold_q != '0);
        game_select_d = select_src | (select_hold_q != '0);

        bw_col_d = bw_col_q ^ bw_rise;
    end

    // Paddle integrators, pot ramp and the comparator levels seen by the TIA.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pad_pos_d[k] = pad_pos_q[k];
            if (k < NUM_JOY && ftick) begin
                if (joy_ext[k][3] && !joy_ext[k][2])
                    pad_pos_d[k] = (pad_pos_q[k] > PAD_MAX - PAD_INC) ? PAD_MAX : pad_pos_q[k] + PAD_INC;
                else if (joy_ext[k][2] && !joy_ext[k][3])
                    pad_pos_d[k] = (pad_pos_q[k] < PAD_INC) ? '0 : pad_pos_q[k] - PAD_INC;
            end
            pad_in_d[k] = !pot_dump_q && (ramp_q >= pad_pos_q[k]);
        end

        ramp_d = ramp_q;
        div_d  = div_q;
        if (pot_dump_q) begin
            ramp_d = '0;
            div_d  = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            if (ramp_q != PAD_MAX)
                ramp_d = ramp_q + 1'b1;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            joy_q         <= '0;
            vsync_q       <= 1'b0;
            vsync_prev_q  <= 1'b0;
            pot_dump_q    <= 1'b0;
            start_prev_q  <= 1'b0;
            select_prev_q <= 1'b0;
            bw_prev_q     <= '0;
            reset_hold_q  <= '0;
            select_hold_q <= '0;
            ramp_q        <= '0;
            div_q         <= '0;
            for (int k = 0; k < 4; k++) pad_pos_q[k] <= PAD_CENTRE;
            ctl_l_q       <= '0;
            ctl_r_q       <= '0;
            trig_l_q      <= 1'b0;
            trig_r_q      <= 1'b0;
            pad_in_q      <= '0;
            game_reset_q  <= 1'b0;
            game_select_q <= 1'b0;
            bw_col_q      <= 1'b1;
`ifdef A26_KEY_INPUT_EN
            ps2_key_q      <= '0;
            key_tgl_prev_q <= 1'b0;
            f1_down_q      <= 1'b0;
            f2_down_q      <= 1'b0;
`endif
        end else begin
            joy_q         <= joy_d;
            vsync_q       <= vsync_d;
            vsync_prev_q  <= vsync_prev_d;
            pot_dump_q    <= pot_dump_d;
            start_prev_q  <= start_prev_d;
            select_prev_q <= select_prev_d;
            bw_prev_q     <= bw_prev_d;
            reset_hold_q  <= reset_hold_d;
            select_hold_q <= select_hold_d;
            ramp_q        <= ramp_d;
            div_q         <= div_d;
            for (int k = 0; k < 4; k++) pad_pos_q[k] <= pad_pos_d[k];
            ctl_l_q       <= ctl_l_d;
            ctl_r_q       <= ctl_r_d;
            trig_l_q      <= trig_l_d;
            trig_r_q      <= trig_r_d;
            pad_in_q      <= pad_in_d;
            game_reset_q  <= game_reset_d;
            game_select_q <= game_select_d;
            bw_col_q      <= bw_col_d;
`ifdef A26_KEY_INPUT_EN
            ps2_key_q      <= ps2_key_d;
            key_tgl_prev_q <= key_tgl_prev_d;
            f1_down_q      <= f1_down_d;
            f2_down_q      <= f2_down_d;
`endif
        end
    end

    // Pack the paddle positions onto the flat output bus, paddle k in slice k.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pad_pos[k*PAD_BITS +: PAD_BITS] = pad_pos_q[k];
        end
    end

    assign ctl_l       = ctl_l_q;
    assign ctl_r       = ctl_r_q;
    assign trig_l      = trig_l_q;
    assign trig_r      = trig_r_q;
    assign pad_in      = pad_in_q;
    assign game_reset  = game_reset_q;
    assign game_select = game_select_q;
    assign bw_col      = bw_col_q;

endmodule

// File: tb/tb_a26_input_mux.sv
// tb_a26_input_mux: directed checks with literal expectations, then randomized
// stimulus compared every cycle against a frame/ramp-level reference model.
module tb_a26_input_mux;

    localparam int NUM_JOY     = 2;
    localparam int PAD_BITS    = 8;
    localparam int PAD_STEP    = 4;
    localparam int RAMP_DIV    = 57;
    localparam int SWITCH_HOLD = 3;
    localparam int PAD_TOP     = (1 << PAD_BITS) - 1;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] joy_i    = 32'h0;
    logic [1:0]  mode     = 2'd0;
    logic        vsync    = 1'b0;
    logic        pot_dump = 1'b1;

    logic [3:0]  ctl_l, ctl_r, pad_in;
    logic        trig_l, trig_r, game_reset, game_select, bw_col;
    logic [31:0] pad_pos;

    int checks   = 0;
    int failures = 0;

    a26_input_mux #(
        .NUM_JOY(NUM_JOY), .PAD_BITS(PAD_BITS), .PAD_STEP(PAD_STEP),
        .RAMP_DIV(RAMP_DIV), .SWITCH_HOLD(SWITCH_HOLD)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .joy_i(joy_i), .mode(mode),
        .vsync(vsync), .pot_dump(pot_dump),
        .ctl_l(ctl_l), .ctl_r(ctl_r), .trig_l(trig_l), .trig_r(trig_r),
        .pad_pos(pad_pos), .pad_in(pad_in),
        .game_reset(game_reset), .game_select(game_select), .bw_col(bw_col)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // s1_* is what the block has latched from the pins, s2_* the copy before that.
    logic [15:0] s1_joy [4];
    logic [15:0] s2_joy [4];
    logic        s1_vs, s2_vs, s1_pot;
    int          m_pos [4];
    int          m_low;
    int          m_hold_r, m_hold_s;
    logic        m_bw;
    bit          model_ok = 1'b0;
    logic [3:0]  e_ctl_l, e_ctl_r, e_pad_in;
    logic        e_trig_l, e_trig_r, e_gr, e_gs, e_bw;
    logic [31:0] e_pos;
    logic [15:0] m_lw, m_rw, m_or;
    int          m_ramp;
    logic        m_src_r, m_src_s, m_prev_r, m_prev_s, m_ftick, m_bw_edge;

    always @(posedge clk_sys) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                s1_joy[k] = 16'h0;
                s2_joy[k] = 16'h0;
                m_pos[k]  = 1 << (PAD_BITS - 1);
            end
            s1_vs = 1'b0; s2_vs = 1'b0; s1_pot = 1'b0;
            m_low = 0; m_hold_r = 0; m_hold_s = 0; m_bw = 1'b1;
            e_ctl_l = 4'h0; e_ctl_r = 4'h0; e_trig_l = 1'b0; e_trig_r = 1'b0;
            e_pad_in = 4'h0; e_gr = 1'b0; e_gs = 1'b0; e_bw = 1'b1;
            e_pos = 32'h80808080;
            model_ok = 1'b1;
        end else begin
            m_or = s1_joy[0] | s1_joy[1] | s1_joy[2] | s1_joy[3];
            case (mode)
                2'd1:    begin m_lw = m_or;      m_rw = m_or;      end
                2'd2:    begin m_lw = s1_joy[1]; m_rw = s1_joy[0]; end
                default: begin m_lw = s1_joy[0]; m_rw = s1_joy[1]; end
            endcase
            e_ctl_l  = m_lw[3:0];
            e_ctl_r  = m_rw[3:0];
            e_trig_l = m_lw[4] | m_lw[6];
            e_trig_r = m_rw[4] | m_rw[6];

            // ramp value = elapsed ramp-enabled cycles / divider, saturating
            m_ramp = m_low / RAMP_DIV;
            if (m_ramp > PAD_TOP) m_ramp = PAD_TOP;
            for (int k = 0; k < 4; k++) e_pad_in[k] = !s1_pot && (m_ramp >= m_pos[k]);

            m_src_r  = m_or[7];
            m_src_s  = m_or[8];
            m_prev_r = s2_joy[0][7] | s2_joy[1][7];
            m_prev_s = s2_joy[0][8] | s2_joy[1][8];
            e_gr = m_src_r || (m_hold_r != 0);
            e_gs = m_src_s || (m_hold_s != 0);

            m_ftick = s1_vs && !s2_vs;
            if (m_ftick) begin
                for (int k = 0; k < NUM_JOY; k++) begin
                    if (s1_joy[k][3] && !s1_joy[k][2])
                        m_pos[k] = (m_pos[k] + PAD_STEP > PAD_TOP) ? PAD_TOP : m_pos[k] + PAD_STEP;
                    else if (s1_joy[k][2] && !s1_joy[k][3])
                        m_pos[k] = (m_pos[k] - PAD_STEP < 0) ? 0 : m_pos[k] - PAD_STEP;
                end
            end
            for (int k = 0; k < 4; k++) e_pos[k*8 +: 8] = 8'(m_pos[k]);

            if (m_src_r && !m_prev_r) m_hold_r = SWITCH_HOLD;
            else if (m_ftick && !m_src_r && m_hold_r > 0) m_hold_r = m_hold_r - 1;
            if (m_src_s && !m_prev_s) m_hold_s = SWITCH_HOLD;
            else if (m_ftick && !m_src_s && m_hold_s > 0) m_hold_s = m_hold_s - 1;

            m_bw_edge = 1'b0;
            for (int k = 0; k < 4; k++) if (s1_joy[k][11] && !s2_joy[k][11]) m_bw_edge = 1'b1;
            if (m_bw_edge) m_bw = !m_bw;
            e_bw = m_bw;

            m_low = s1_pot ? 0 : m_low + 1;

            s2_vs = s1_vs;
            for (int k = 0; k < 4; k++) s2_joy[k] = s1_joy[k];
            s1_joy[0] = joy_i[15:0];
            s1_joy[1] = joy_i[31:16];
            s1_joy[2] = 16'h0;
            s1_joy[3] = 16'h0;
            s1_vs  = vsync;
            s1_pot = pot_dump;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk_sys) begin
        if (model_ok) begin
            checkOutput("m_ctl_l", 32'(ctl_l), 32'(e_ctl_l));
            checkOutput("m_ctl_r", 32'(ctl_r), 32'(e_ctl_r));
            checkOutput("m_trig", 32'({trig_l, trig_r}), 32'({e_trig_l, e_trig_r}));
            checkOutput("m_pad_pos", pad_pos, e_pos);
            checkOutput("m_pad_in", 32'(pad_in), 32'(e_pad_in));
            checkOutput("m_switches", 32'({game_reset, game_select}), 32'({e_gr, e_gs}));
            checkOutput("m_bw_col", 32'(bw_col), 32'(e_bw));
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic [15:0] j0, input logic [15:0] j1, input int cycles);
        joy_i = {j1, j0};
        repeat (cycles) @(negedge clk_sys);
    endtask

    task automatic vsyncPulse(input int n);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b1;
            repeat (2) @(negedge clk_sys);
            vsync = 1'b0;
            repeat (2) @(negedge clk_sys);
        end
    endtask

    function automatic logic [15:0] randomWord(input logic [3:0] dir);
        logic [31:0] r;
        logic [15:0] w;
        r     = $urandom;
        w     = r[15:0] & 16'hF670;
        w[3:0] = dir;
        w[7]  = ($urandom_range(0, 29) == 0);
        w[8]  = ($urandom_range(0, 29) == 0);
        w[11] = ($urandom_range(0, 29) == 0);
        return w;
    endfunction

    logic [3:0] dirs [2];
    int vs_cnt, pot_cnt, wait_n;
    bit got;

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        checkOutput("reset_pad_pos", pad_pos, 32'h80808080);
        checkOutput("reset_bw_col", 32'(bw_col), 32'h1);
        checkOutput("reset_ctl", 32'({ctl_l, ctl_r}), 32'h0);
        checkOutput("reset_misc", 32'({trig_l, trig_r, pad_in, game_reset, game_select}), 32'h0);

        mode = 2'd0;
        applyStimulus(16'h0010, 16'h0001, 2);
        checkOutput("mode0_trig_l", 32'(trig_l), 32'h1);
        checkOutput("mode0_ctl_r", 32'(ctl_r), 32'h1);
        checkOutput("mode0_ctl_l_trig_r", 32'({ctl_l, trig_r}), 32'h0);
        mode = 2'd2;
        @(negedge clk_sys);
        checkOutput("mode2_trig_r", 32'(trig_r), 32'h1);
        checkOutput("mode2_ctl_l", 32'(ctl_l), 32'h1);
        checkOutput("mode2_ctl_r_trig_l", 32'({ctl_r, trig_l}), 32'h0);
        mode = 2'd0;
        applyStimulus(16'h0, 16'h0, 2);

        applyStimulus(16'h0008, 16'h0, 1);
        vsyncPulse(1);
        checkOutput("pad_first_step", 32'(pad_pos[7:0]), 32'd132);
        vsyncPulse(39);
        checkOutput("pad_sat_high", 32'(pad_pos[7:0]), 32'd255);
        checkOutput("pad1_idle", 32'(pad_pos[15:8]), 32'd128);
        applyStimulus(16'h000C, 16'h0, 1);
        vsyncPulse(3);
        checkOutput("pad_lr_hold", 32'(pad_pos[7:0]), 32'd255);
        applyStimulus(16'h0004, 16'h0, 1);
        vsyncPulse(70);
        checkOutput("pad_sat_low", 32'(pad_pos[7:0]), 32'd0);
        applyStimulus(16'h0008, 16'h0, 1);
        vsyncPulse(3);
        checkOutput("pad_back_up", 32'(pad_pos[7:0]), 32'd12);
        applyStimulus(16'h0, 16'h0, 2);

        pot_dump = 1'b0;
        wait_n = 0;
        got = 1'b0;
        while (!got && wait_n < 3000) begin
            @(posedge clk_sys);
            wait_n++;
            @(negedge clk_sys);
            if (pad_in[0]) got = 1'b1;
        end
        checkOutput("ramp_latency", 32'(wait_n), 32'(12 * 57 + 2));
        checkOutput("ramp_other_pads", 32'(pad_in[3:1]), 32'h0);
        pot_dump = 1'b1;
        repeat (2) @(negedge clk_sys);
        checkOutput("pot_dump_clears", 32'(pad_in), 32'h0);

        applyStimulus(16'h0080, 16'h0, 1);
        applyStimulus(16'h0, 16'h0, 1);
        checkOutput("start_on", 32'(game_reset), 32'h1);
        vsyncPulse(1);
        checkOutput("start_hold1", 32'(game_reset), 32'h1);
        vsyncPulse(1);
        checkOutput("start_hold2", 32'(game_reset), 32'h1);
        vsyncPulse(1);
        checkOutput("start_released", 32'(game_reset), 32'h0);

        applyStimulus(16'h0080, 16'h0, 1);
        applyStimulus(16'h0, 16'h0, 1);
        vsyncPulse(2);
        checkOutput("start_before_repress", 32'(game_reset), 32'h1);
        applyStimulus(16'h0080, 16'h0, 1);
        applyStimulus(16'h0, 16'h0, 1);
        vsyncPulse(2);
        checkOutput("start_reloaded", 32'(game_reset), 32'h1);
        vsyncPulse(1);
        checkOutput("start_reload_end", 32'(game_reset), 32'h0);

        applyStimulus(16'h0, 16'h0100, 1);
        applyStimulus(16'h0, 16'h0, 1);
        checkOutput("select_on", 32'(game_select), 32'h1);
        vsyncPulse(3);
        checkOutput("select_released", 32'(game_select), 32'h0);

        applyStimulus(16'h0800, 16'h0800, 1);
        applyStimulus(16'h0, 16'h0, 1);
        checkOutput("bw_single_toggle", 32'(bw_col), 32'h0);
        applyStimulus(16'h0800, 16'h0800, 1);
        applyStimulus(16'h0, 16'h0, 1);
        checkOutput("bw_restore", 32'(bw_col), 32'h1);

        dirs[0] = 4'h8;
        dirs[1] = 4'h4;
        vs_cnt  = 0;
        pot_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset = ($urandom_range(0, 599) == 0);
            if (vs_cnt == 0) begin
                vsync  = ~vsync;
                vs_cnt = $urandom_range(1, 8);
            end else begin
                vs_cnt--;
            end
            if (pot_cnt == 0) begin
                pot_dump = ~pot_dump;
                pot_cnt  = pot_dump ? $urandom_range(1, 10) : $urandom_range(20, 1200);
            end else begin
                pot_cnt--;
            end
            if ($urandom_range(0, 99) == 0) mode = 2'($urandom);
            for (int k = 0; k < 2; k++)
                if ($urandom_range(0, 49) == 0) dirs[k] = 4'($urandom);
            joy_i = {randomWord(dirs[1]), randomWord(dirs[0])};
            @(negedge clk_sys);
        end
        reset = 1'b0;
        joy_i = 32'h0;
        repeat (4) @(negedge clk_sys);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
